div_sqrt_issue_ctrl: RTL and testbench

Issue controller and arbiter for the shared div/sqrt unit. It accepts divide and square-root requests from NUM_REQ requesters over valid/ready handshakes and picks one by round-robin. It drives the single-cycle start pulse, operands and rounding mode into the preprocessing stage, then tracks the in-flight operation with a watchdog counter and returns the tagged result to the originating requester.

---
 rtl/div_sqrt_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_div_sqrt_issue_ctrl.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sqrt_issue_ctrl.sv
// Issue controller for the shared div/sqrt unit: round-robin arbitration over
// NUM_REQ requesters, start/operand issue, watchdog tracking and tagged response.
module div_sqrt_issue_ctrl #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned OP_W    = 32,
    parameter int unsigned RM_W    = 3,
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned WDOG_W  = 6
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    input  logic [NUM_REQ-1:0]      Req_valid_SI,
    output logic [NUM_REQ-1:0]      Req_ready_SO,
    input  logic [NUM_REQ-1:0]      Req_op_SI,
    input  logic [NUM_REQ*OP_W-1:0] Req_operand_a_DI,
    input  logic [NUM_REQ*OP_W-1:0] Req_operand_b_DI,
    input  logic [NUM_REQ*RM_W-1:0] Req_rm_SI,
    output logic                    Div_start_SO,
    output logic                    Sqrt_start_SO,
    output logic [OP_W-1:0]         Operand_a_DO,
    output logic [OP_W-1:0]         Operand_b_DO,
    output logic [RM_W-1:0]         RM_SO,
    output logic                    Kill_SO,
    input  logic                    Done_SI,
    input  logic [OP_W-1:0]         Result_DI,
    input  logic [4:0]              Flags_DI,
    input  logic                    Kill_SI,
    output logic [NUM_REQ-1:0]      Resp_valid_SO,
    input  logic [NUM_REQ-1:0]      Resp_ready_SI,
    output logic [OP_W-1:0]         Resp_result_DO,
    output logic [4:0]              Resp_flags_DO,
    output logic                    Resp_timeout_SO,
    output logic                    Busy_SO
);

    localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_e;

    state_e            state_d, state_q;
    logic [TAG_W-1:0]  ptr_d, ptr_q;
    logic [TAG_W-1:0]  owner_d, owner_q;
    logic [WDOG_W-1:0] wdog_d, wdog_q;
    logic [OP_W-1:0]   result_d, result_q;
    logic [4:0]        flags_d, flags_q;
    logic              timeout_d, timeout_q;

    logic              grant_valid;
    logic [TAG_W-1:0]  grant_idx;
    logic              accept;

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            automatic logic [TAG_W-1:0] idx = TAG_W'((ptr_q + i) % NUM_REQ);
            if (!grant_valid && Req_valid_SI[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Reset is folded in so ready and the start pulses stay low while held in reset.
    assign accept = Rst_RBI && (state_q == IDLE) && !Kill_SI && grant_valid;

    always_comb begin
        Req_ready_SO = '0;
        if (accept) Req_ready_SO[grant_idx] = 1'b1;
    end

    assign Div_start_SO  = accept && !Req_op_SI[grant_idx];
    assign Sqrt_start_SO = accept &&  Req_op_SI[grant_idx];
    assign Operand_a_DO  = accept ? Req_operand_a_DI[grant_idx*OP_W +: OP_W] : '0;
    assign Operand_b_DO  = accept ? Req_operand_b_DI[grant_idx*OP_W +: OP_W] : '0;
    assign RM_SO         = accept ? Req_rm_SI[grant_idx*RM_W +: RM_W] : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        wdog_d    = wdog_q;
        result_d  = result_q;
        flags_d   = flags_q;
        timeout_d = timeout_q;
        Kill_SO   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant_idx;
                    ptr_d   = TAG_W'((grant_idx + 1) % NUM_REQ);
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Done in the final watchdog cycle wins over the abort.
                if (Kill_SI) begin
                    state_d = IDLE;
                end else if (Done_SI) begin
                    result_d  = Result_DI;
                    flags_d   = Flags_DI;
                    timeout_d = 1'b0;
                    state_d   = HOLD;
                end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
                    Kill_SO   = 1'b1;
                    result_d  = '0;
                    flags_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            HOLD: begin
                if (Kill_SI || Resp_ready_SI[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the result/flag registers are reset too because their
    // outputs must read 0 while reset is held.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            wdog_q    <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            wdog_q    <= wdog_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        Resp_valid_SO = '0;
        if (state_q == HOLD) Resp_valid_SO[owner_q] = 1'b1;
    end

    assign Resp_result_DO  = result_q;
    assign Resp_flags_DO   = flags_q;
    assign Resp_timeout_SO = timeout_q && (state_q == HOLD);
    assign Busy_SO         = (state_q != IDLE);

endmodule

// File: tb/tb_div_sqrt_issue_ctrl.sv
// Directed bench for div_sqrt_issue_ctrl: one task per scenario with inline
// comparisons against hand-computed values, then a one-line summary.
module tb_div_sqrt_issue_ctrl;

    localparam int NUM_REQ = 2;
    localparam int OP_W    = 32;
    localparam int RM_W    = 3;
    localparam int TIMEOUT = 63;
    localparam int WDOG_W  = 6;

    logic                    Clk_CI = 1'b0;
    logic                    Rst_RBI = 1'b0;
    logic [NUM_REQ-1:0]      Req_valid_SI;
    logic [NUM_REQ-1:0]      Req_ready_SO;
    logic [NUM_REQ-1:0]      Req_op_SI;
    logic [NUM_REQ*OP_W-1:0] Req_operand_a_DI;
    logic [NUM_REQ*OP_W-1:0] Req_operand_b_DI;
    logic [NUM_REQ*RM_W-1:0] Req_rm_SI;
    logic                    Div_start_SO;
    logic                    Sqrt_start_SO;
    logic [OP_W-1:0]         Operand_a_DO;
    logic [OP_W-1:0]         Operand_b_DO;
    logic [RM_W-1:0]         RM_SO;
    logic                    Kill_SO;
    logic                    Done_SI;
    logic [OP_W-1:0]         Result_DI;
    logic [4:0]              Flags_DI;
    logic                    Kill_SI;
    logic [NUM_REQ-1:0]      Resp_valid_SO;
    logic [NUM_REQ-1:0]      Resp_ready_SI;
    logic [OP_W-1:0]         Resp_result_DO;
    logic [4:0]              Resp_flags_DO;
    logic                    Resp_timeout_SO;
    logic                    Busy_SO;

    int checks = 0;
    int errors = 0;

    always #5 Clk_CI = ~Clk_CI;

    div_sqrt_issue_ctrl #(
        .NUM_REQ(NUM_REQ), .OP_W(OP_W), .RM_W(RM_W), .TIMEOUT(TIMEOUT), .WDOG_W(WDOG_W)
    ) dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
        .Req_valid_SI(Req_valid_SI), .Req_ready_SO(Req_ready_SO), .Req_op_SI(Req_op_SI),
        .Req_operand_a_DI(Req_operand_a_DI), .Req_operand_b_DI(Req_operand_b_DI),
        .Req_rm_SI(Req_rm_SI), .Div_start_SO(Div_start_SO), .Sqrt_start_SO(Sqrt_start_SO),
        .Operand_a_DO(Operand_a_DO), .Operand_b_DO(Operand_b_DO), .RM_SO(RM_SO),
        .Kill_SO(Kill_SO), .Done_SI(Done_SI), .Result_DI(Result_DI), .Flags_DI(Flags_DI),
        .Kill_SI(Kill_SI), .Resp_valid_SO(Resp_valid_SO), .Resp_ready_SI(Resp_ready_SI),
        .Resp_result_DO(Resp_result_DO), .Resp_flags_DO(Resp_flags_DO),
        .Resp_timeout_SO(Resp_timeout_SO), .Busy_SO(Busy_SO)
    );

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge Clk_CI);
        #2;
    endtask

    task automatic idle_inputs();
        Req_valid_SI     = '0;
        Req_op_SI        = '0;
        Req_operand_a_DI = '0;
        Req_operand_b_DI = '0;
        Req_rm_SI        = '0;
        Done_SI          = 1'b0;
        Result_DI        = '0;
        Flags_DI         = '0;
        Kill_SI          = 1'b0;
        Resp_ready_SI    = '0;
    endtask

    task automatic set_req(input int idx, input logic op, input logic [OP_W-1:0] a,
                           input logic [OP_W-1:0] b, input logic [RM_W-1:0] rm);
        Req_valid_SI[idx]                 = 1'b1;
        Req_op_SI[idx]                    = op;
        Req_operand_a_DI[idx*OP_W +: OP_W] = a;
        Req_operand_b_DI[idx*OP_W +: OP_W] = b;
        Req_rm_SI[idx*RM_W +: RM_W]        = rm;
    endtask

    task automatic apply_reset();
        idle_inputs();
        Rst_RBI = 1'b0;
        step();
        step();
        Rst_RBI = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst_RBI       = 1'b0;
        Req_valid_SI  = 2'b11;
        Done_SI       = 1'b1;
        Resp_ready_SI = 2'b11;
        step();
        #1;
        checks++;
        if ({Req_ready_SO, Div_start_SO, Sqrt_start_SO, Kill_SO, Resp_valid_SO,
             Resp_timeout_SO, Busy_SO} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b div=%b sqrt=%b kill=%b rvalid=%b to=%b busy=%b exp all 0",
                     Req_ready_SO, Div_start_SO, Sqrt_start_SO, Kill_SO, Resp_valid_SO,
                     Resp_timeout_SO, Busy_SO);
        end
        checks++;
        if ({Operand_a_DO, Operand_b_DO, RM_SO, Resp_result_DO, Resp_flags_DO} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h rm=%h res=%h flags=%h exp all 0",
                     Operand_a_DO, Operand_b_DO, RM_SO, Resp_result_DO, Resp_flags_DO);
        end
        idle_inputs();
        Rst_RBI = 1'b1;
        step();
        #1;
        checks++;
        if (Busy_SO !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got %b exp 0", Busy_SO);
        end
    endtask

    task automatic test_single_div();
        apply_reset();
        set_req(0, 1'b0, 32'h4040_0000, 32'h3F80_0000, 3'd0);
        #1;
        checks++;
        if (Req_ready_SO !== 2'b01 || Div_start_SO !== 1'b1 || Sqrt_start_SO !== 1'b0) begin
            errors++;
            $display("FAIL single_issue got ready=%b div=%b sqrt=%b exp 01 1 0",
                     Req_ready_SO, Div_start_SO, Sqrt_start_SO);
        end
        checks++;
        if (Operand_a_DO !== 32'h4040_0000 || Operand_b_DO !== 32'h3F80_0000 || RM_SO !== 3'd0) begin
            errors++;
            $display("FAIL single_operands got a=%h b=%h rm=%0d exp 40400000 3f800000 0",
                     Operand_a_DO, Operand_b_DO, RM_SO);
        end
        step();
        Req_valid_SI = '0;
        #1;
        checks++;
        if (Div_start_SO !== 1'b0 || Busy_SO !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse_len got div=%b busy=%b exp 0 1", Div_start_SO, Busy_SO);
        end
        for (int k = 1; k <= 11; k++) begin
            checks++;
            if (Resp_valid_SO !== 2'b00 || Div_start_SO !== 1'b0) begin
                errors++;
                $display("FAIL single_wait T+%0d got rvalid=%b div=%b exp 00 0", k, Resp_valid_SO, Div_start_SO);
            end
            step();
            #1;
        end
        Done_SI   = 1'b1;
        Result_DI = 32'h4040_0000;
        Flags_DI  = 5'h00;
        step();
        Done_SI = 1'b0;
        #1;
        checks++;
        if (Resp_valid_SO !== 2'b01 || Resp_result_DO !== 32'h4040_0000 ||
            Resp_flags_DO !== 5'h00 || Resp_timeout_SO !== 1'b0) begin
            errors++;
            $display("FAIL single_resp got rvalid=%b res=%h flags=%h to=%b exp 01 40400000 00 0",
                     Resp_valid_SO, Resp_result_DO, Resp_flags_DO, Resp_timeout_SO);
        end
        Resp_ready_SI = 2'b01;
        step();
        Resp_ready_SI = 2'b00;
        #1;
        checks++;
        if (Busy_SO !== 1'b0 || Resp_valid_SO !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got busy=%b rvalid=%b exp 0 00", Busy_SO, Resp_valid_SO);
        end
    endtask

    task automatic test_alternate();
        logic [OP_W-1:0] exp_a;
        logic [RM_W-1:0] exp_rm;
        logic [1:0]      exp_oh;
        apply_reset();
        set_req(0, 1'b1, 32'h1111_0000, 32'h2222_0000, 3'd2);
        set_req(1, 1'b0, 32'hAAAA_0001, 32'hBBBB_0001, 3'd5);
        for (int n = 0; n < 4; n++) begin
            exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_a  = (n % 2 == 0) ? 32'h1111_0000 : 32'hAAAA_0001;
            exp_rm = (n % 2 == 0) ? 3'd2 : 3'd5;
            #1;
            checks++;
            if (Req_ready_SO !== exp_oh || Sqrt_start_SO !== (n % 2 == 0) ||
                Div_start_SO !== (n % 2 == 1)) begin
                errors++;
                $display("FAIL alt_grant n=%0d got ready=%b sqrt=%b div=%b exp ready=%b",
                         n, Req_ready_SO, Sqrt_start_SO, Div_start_SO, exp_oh);
            end
            checks++;
            if (Operand_a_DO !== exp_a || RM_SO !== exp_rm) begin
                errors++;
                $display("FAIL alt_operands n=%0d got a=%h rm=%0d exp a=%h rm=%0d",
                         n, Operand_a_DO, RM_SO, exp_a, exp_rm);
            end
            step();
            #1;
            checks++;
            if (Req_ready_SO !== 2'b00) begin
                errors++;
                $display("FAIL alt_busy_ready n=%0d got %b exp 00", n, Req_ready_SO);
            end
            Done_SI   = 1'b1;
            Result_DI = 32'h0000_1000 + n;
            step();
            Done_SI = 1'b0;
            #1;
            checks++;
            if (Resp_valid_SO !== exp_oh || Resp_result_DO !== 32'h0000_1000 + n) begin
                errors++;
                $display("FAIL alt_resp n=%0d got rvalid=%b res=%h exp rvalid=%b res=%h",
                         n, Resp_valid_SO, Resp_result_DO, exp_oh, 32'h0000_1000 + n);
            end
            Resp_ready_SI = exp_oh;
            step();
            Resp_ready_SI = 2'b00;
        end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        logic early_kill;
        apply_reset();
        // Done in the final watchdog cycle: result returned, no abort.
        set_req(0, 1'b0, 32'h4000_0000, 32'h4000_0000, 3'd1);
        step();
        Req_valid_SI = '0;
        early_kill = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            #1;
            if (Kill_SO !== 1'b0) early_kill = 1'b1;
            step();
        end
        checks++;
        if (early_kill !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early_kill_a got %b exp 0", early_kill);
        end
        Done_SI   = 1'b1;
        Result_DI = 32'hCAFE_F00D;
        Flags_DI  = 5'h01;
        #1;
        checks++;
        if (Kill_SO !== 1'b0) begin
            errors++;
            $display("FAIL wdog_done_wins_kill got %b exp 0", Kill_SO);
        end
        step();
        Done_SI = 1'b0;
        #1;
        checks++;
        if (Resp_valid_SO !== 2'b01 || Resp_result_DO !== 32'hCAFE_F00D ||
            Resp_flags_DO !== 5'h01 || Resp_timeout_SO !== 1'b0) begin
            errors++;
            $display("FAIL wdog_done_resp got rvalid=%b res=%h flags=%h to=%b exp 01 cafef00d 01 0",
                     Resp_valid_SO, Resp_result_DO, Resp_flags_DO, Resp_timeout_SO);
        end
        Resp_ready_SI = 2'b01;
        step();
        Resp_ready_SI = 2'b00;
        // No Done at all: abort at T+1+TIMEOUT.
        set_req(0, 1'b1, 32'h4080_0000, 32'h0, 3'd0);
        step();
        Req_valid_SI = '0;
        early_kill = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            #1;
            if (Kill_SO !== 1'b0 || Busy_SO !== 1'b1) early_kill = 1'b1;
            step();
        end
        checks++;
        if (early_kill !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early_kill_b got %b exp 0", early_kill);
        end
        #1;
        checks++;
        if (Kill_SO !== 1'b1) begin
            errors++;
            $display("FAIL wdog_kill_pulse got %b exp 1", Kill_SO);
        end
        step();
        #1;
        checks++;
        if (Kill_SO !== 1'b0 || Resp_valid_SO !== 2'b01 || Resp_result_DO !== 32'h0 ||
            Resp_flags_DO !== 5'h00 || Resp_timeout_SO !== 1'b1) begin
            errors++;
            $display("FAIL wdog_timeout_resp got kill=%b rvalid=%b res=%h flags=%h to=%b exp 0 01 0 0 1",
                     Kill_SO, Resp_valid_SO, Resp_result_DO, Resp_flags_DO, Resp_timeout_SO);
        end
        Resp_ready_SI = 2'b01;
        step();
        Resp_ready_SI = 2'b00;
    endtask

    task automatic test_backpressure();
        logic bad;
        idle_inputs();
        set_req(1, 1'b1, 32'h4000_0000, 32'h0, 3'd3);
        #1;
        checks++;
        if (Req_ready_SO !== 2'b10 || Sqrt_start_SO !== 1'b1) begin
            errors++;
            $display("FAIL bp_issue got ready=%b sqrt=%b exp 10 1", Req_ready_SO, Sqrt_start_SO);
        end
        step();
        Req_valid_SI = '0;
        Done_SI      = 1'b1;
        Result_DI    = 32'h3FB5_04F3;
        Flags_DI     = 5'h01;
        step();
        Done_SI   = 1'b0;
        Result_DI = 32'hDEAD_BEEF;
        Flags_DI  = 5'h1F;
        Req_valid_SI[0] = 1'b1;
        Resp_ready_SI   = 2'b01;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (Resp_valid_SO !== 2'b10 || Resp_result_DO !== 32'h3FB5_04F3 ||
                Resp_flags_DO !== 5'h01 || Req_ready_SO !== 2'b00) bad = 1'b1;
            step();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_stable got rvalid=%b res=%h flags=%h ready=%b exp 10 3fb504f3 01 00",
                     Resp_valid_SO, Resp_result_DO, Resp_flags_DO, Req_ready_SO);
        end
        Resp_ready_SI = 2'b10;
        step();
        Resp_ready_SI = 2'b00;
        #1;
        checks++;
        if (Busy_SO !== 1'b0 || Resp_valid_SO !== 2'b00 || Req_ready_SO !== 2'b01) begin
            errors++;
            $display("FAIL bp_idle_after got busy=%b rvalid=%b ready=%b exp 0 00 01",
                     Busy_SO, Resp_valid_SO, Req_ready_SO);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_kill();
        idle_inputs();
        // Kill in BUSY, together with Done.
        set_req(0, 1'b0, 32'h1234_5678, 32'h1, 3'd0);
        #1;
        checks++;
        if (Req_ready_SO !== 2'b01) begin
            errors++;
            $display("FAIL kill_a_issue got ready=%b exp 01", Req_ready_SO);
        end
        step();
        Req_valid_SI = '0;
        Kill_SI      = 1'b1;
        Done_SI      = 1'b1;
        Result_DI    = 32'h5555_5555;
        #1;
        checks++;
        if (Kill_SO !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy_no_killso got %b exp 0", Kill_SO);
        end
        step();
        Kill_SI = 1'b0;
        Done_SI = 1'b0;
        #1;
        checks++;
        if (Busy_SO !== 1'b0 || Resp_valid_SO !== 2'b00) begin
            errors++;
            $display("FAIL kill_busy_idle got busy=%b rvalid=%b exp 0 00", Busy_SO, Resp_valid_SO);
        end
        // Kill in IDLE blocks acceptance for that cycle only.
        set_req(1, 1'b0, 32'h0BAD_0001, 32'h2, 3'd4);
        Kill_SI = 1'b1;
        #1;
        checks++;
        if (Req_ready_SO !== 2'b00 || Div_start_SO !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_block got ready=%b div=%b exp 00 0", Req_ready_SO, Div_start_SO);
        end
        step();
        Kill_SI = 1'b0;
        #1;
        checks++;
        if (Busy_SO !== 1'b0 || Req_ready_SO !== 2'b10 || Div_start_SO !== 1'b1 ||
            Operand_a_DO !== 32'h0BAD_0001 || RM_SO !== 3'd4) begin
            errors++;
            $display("FAIL kill_idle_release got busy=%b ready=%b div=%b a=%h rm=%0d exp 0 10 1 0bad0001 4",
                     Busy_SO, Req_ready_SO, Div_start_SO, Operand_a_DO, RM_SO);
        end
        step();
        Req_valid_SI = '0;
        Done_SI      = 1'b1;
        Result_DI    = 32'h7777_0000;
        step();
        Done_SI = 1'b0;
        // Kill beats the owner's ready in HOLD.
        Kill_SI       = 1'b1;
        Resp_ready_SI = 2'b10;
        #1;
        checks++;
        if (Resp_valid_SO !== 2'b10) begin
            errors++;
            $display("FAIL kill_hold_pre got rvalid=%b exp 10", Resp_valid_SO);
        end
        step();
        Kill_SI       = 1'b0;
        Resp_ready_SI = 2'b00;
        #1;
        checks++;
        if (Busy_SO !== 1'b0 || Resp_valid_SO !== 2'b00) begin
            errors++;
            $display("FAIL kill_hold_idle got busy=%b rvalid=%b exp 0 00", Busy_SO, Resp_valid_SO);
        end
        // A following request goes through normally.
        set_req(0, 1'b1, 32'h4110_0000, 32'h0, 3'd1);
        #1;
        checks++;
        if (Req_ready_SO !== 2'b01 || Sqrt_start_SO !== 1'b1) begin
            errors++;
            $display("FAIL kill_follow_issue got ready=%b sqrt=%b exp 01 1", Req_ready_SO, Sqrt_start_SO);
        end
        step();
        Req_valid_SI = '0;
        Done_SI      = 1'b1;
        Result_DI    = 32'h4040_0000;
        Flags_DI     = 5'h00;
        step();
        Done_SI = 1'b0;
        #1;
        checks++;
        if (Resp_valid_SO !== 2'b01 || Resp_result_DO !== 32'h4040_0000) begin
            errors++;
            $display("FAIL kill_follow_resp got rvalid=%b res=%h exp 01 40400000", Resp_valid_SO, Resp_result_DO);
        end
        Resp_ready_SI = 2'b01;
        step();
        Resp_ready_SI = 2'b00;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        // Accepting requester 0 moves the pointer to 1 before the reset.
        set_req(0, 1'b0, 32'h4000_0000, 32'h3F80_0000, 3'd2);
        step();
        Req_valid_SI = '0;
        Done_SI      = 1'b1;
        Result_DI    = 32'h9999_AAAA;
        Flags_DI     = 5'h10;
        step();
        Done_SI = 1'b0;
        #1;
        checks++;
        if (Resp_valid_SO !== 2'b01 || Resp_result_DO !== 32'h9999_AAAA) begin
            errors++;
            $display("FAIL arst_pre_hold got rvalid=%b res=%h exp 01 9999aaaa", Resp_valid_SO, Resp_result_DO);
        end
        Req_valid_SI = 2'b11;
        #1;
        Rst_RBI = 1'b0;
        #1;
        checks++;
        if (Busy_SO !== 1'b0 || Resp_valid_SO !== 2'b00 || Req_ready_SO !== 2'b00 ||
            Resp_result_DO !== 32'h0 || Resp_flags_DO !== 5'h00 || Kill_SO !== 1'b0 ||
            Div_start_SO !== 1'b0 || Sqrt_start_SO !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate got busy=%b rvalid=%b ready=%b res=%h flags=%h exp all 0",
                     Busy_SO, Resp_valid_SO, Req_ready_SO, Resp_result_DO, Resp_flags_DO);
        end
        step();
        Rst_RBI = 1'b1;
        #1;
        checks++;
        if (Req_ready_SO !== 2'b01) begin
            errors++;
            $display("FAIL arst_pointer got ready=%b exp 01", Req_ready_SO);
        end
        Req_valid_SI = '0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_div();
        test_alternate();
        test_watchdog();
        test_backpressure();
        test_kill();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
